// File: rtl/restador_serial_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// The master side issues start with the operands. The slave side returns
// the status, the difference and the flags.
interface restador_serial_if #(
  parameter int WIDTH = 4
) ();
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] D;
  logic             borrow_out;
  logic             overflow;
  logic             zero;

  modport master (
    output start, A, B, Bin,
    input  busy, done, D, borrow_out, overflow, zero
  );

  modport slave (
    input  start, A, B, Bin,
    output busy, done, D, borrow_out, overflow, zero
  );
endinterface

// File: rtl/restador_serial.sv
// Bit-serial subtractor that computes D = A - B - Bin, LSB first, one bit per clock.
// The datapath is one full-subtractor cell fed from two operand shift registers.
// The result register fills from the MSB side, so D is LSB-aligned once the
// last bit is in. D and all flags hold until the next operation completes.
module restador_serial #(
  parameter int WIDTH = 4
) (
  input logic             clk,
  input logic             rst_n,
  restador_serial_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [WIDTH-2:0] res_sh;
  logic             br;
  logic [CNT_W-1:0] idx;
  logic             a_msb, b_msb;
  logic             d_bit, br_next;
  logic             last_bit;
  logic [WIDTH-1:0] d_final;
  logic [WIDTH-1:0] d_reg;
  logic             borrow_reg, ovf_reg, zero_reg;

  // One full-subtractor cell: returns {borrow_next, difference}.
  function automatic logic [1:0] full_sub(input logic a, input logic b, input logic bi);
    return {(~a & b) | (~(a ^ b) & bi), a ^ b ^ bi};
  endfunction

  assign {br_next, d_bit} = full_sub(a_sh[0], b_sh[0], br);
  assign last_bit         = (idx == CNT_W'(WIDTH - 1));
  // Full result as it stands after the current bit has been shifted in.
  assign d_final          = {d_bit, res_sh};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; busy and done are decoded from the registered state.
  always_comb begin
    state_next = state;
    bus.busy   = 1'b0;
    bus.done   = 1'b0;
    case (state)
      IDLE: if (bus.start) state_next = RUN;
      RUN: begin
        bus.busy = 1'b1;
        if (last_bit) state_next = FIN;
      end
      FIN: begin
        bus.done   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, the serial bit step and the result/flag update on the last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh       <= '0;
      b_sh       <= '0;
      res_sh     <= '0;
      br         <= 1'b0;
      idx        <= '0;
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      d_reg      <= '0;
      borrow_reg <= 1'b0;
      ovf_reg    <= 1'b0;
      zero_reg   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sh  <= bus.A;
            b_sh  <= bus.B;
            br    <= bus.Bin;
            idx   <= '0;
            // The sign bits are kept aside because the shift registers lose them.
            a_msb <= bus.A[WIDTH-1];
            b_msb <= bus.B[WIDTH-1];
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          br     <= br_next;
          res_sh <= d_final[WIDTH-1:1];
          idx    <= idx + 1'b1;
          if (last_bit) begin
            d_reg      <= d_final;
            borrow_reg <= br_next;
            zero_reg   <= (d_final == '0);
            ovf_reg    <= (a_msb != b_msb) && (d_final[WIDTH-1] != a_msb);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.D          = d_reg;
  assign bus.borrow_out = borrow_reg;
  assign bus.overflow   = ovf_reg;
  assign bus.zero       = zero_reg;

endmodule

// File: tb/tb_restador_serial.sv
// Scoreboard bench for the bit-serial subtractor. Each accepted operation
// pushes its expected result, and the result is popped when done is seen.
module tb_restador_serial;

  localparam int W = 4;

  typedef struct packed {
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
    logic         z;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  exp_t q[$];
  exp_t e;
  logic prev_done;

  restador_serial_if #(.WIDTH(W)) bus ();

  restador_serial #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference model built from integer arithmetic and signed interpretation.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    int               diff;
    exp_t             r;
    logic signed [W-1:0] sa, sb, sd;
    diff = int'(a) - int'(b) - int'(bin);
    r.d  = W'(diff);
    r.bo = (diff < 0);
    r.z  = (r.d == '0);
    sa   = a;
    sb   = b;
    sd   = r.d;
    r.ov = ((sa < 0) != (sb < 0)) && ((sd < 0) != (sa < 0));
    return r;
  endfunction

  // Check every done against the scoreboard and that done never lasts two cycles.
  always @(negedge clk) begin
    if (bus.done) begin
      chk("done_pulse", {31'b0, prev_done}, 0);
      chk("done_expected", 32'(q.size() > 0), 1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("D", 32'(bus.D), 32'(e.d));
        chk("borrow_out", {31'b0, bus.borrow_out}, {31'b0, e.bo});
        chk("overflow", {31'b0, bus.overflow}, {31'b0, e.ov});
        chk("zero", {31'b0, bus.zero}, {31'b0, e.z});
      end
    end
    prev_done <= bus.done;
  end

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                        input bit intrude);
    int g;
    int cyc;
    int busy_n;
    bit got;
    @(negedge clk);
    g = 0;
    while ((bus.busy || bus.done) && g < 20) begin
      @(negedge clk);
      g++;
    end
    bus.A     = a;
    bus.B     = b;
    bus.Bin   = bin;
    bus.start = 1'b1;
    q.push_back(model(a, b, bin));
    @(posedge clk);
    #1 bus.start = 1'b0;
    cyc    = 0;
    busy_n = 0;
    got    = 0;
    while (!got && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (bus.busy) busy_n++;
      if (bus.done) got = 1;
      if (intrude && cyc == 2) begin
        bus.start = 1'b1;
        bus.A     = 1;
        bus.B     = 1;
      end
      if (intrude && cyc == 3) bus.start = 1'b0;
    end
    chk("latency", cyc, W + 1);
    chk("busy_cycles", busy_n, W);
    @(negedge clk);
    chk("done_low", {31'b0, bus.done}, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    prev_done = 1'b0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    bus.Bin   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'b0, bus.busy}, 0);
    chk("rst_done", {31'b0, bus.done}, 0);
    chk("rst_D", 32'(bus.D), 0);
    chk("rst_flags", {29'b0, bus.borrow_out, bus.overflow, bus.zero}, 0);
    rst_n = 1'b1;

    run_op(4'd7, 4'd3, 1'b0, 0);
    run_op(4'd3, 4'd7, 1'b0, 0);
    run_op(4'd8, 4'd1, 1'b0, 0);
    run_op(4'd7, 4'd15, 1'b0, 0);
    run_op(4'd5, 4'd4, 1'b1, 0);
    run_op(4'd0, 4'd0, 1'b1, 0);
    run_op(4'd9, 4'd2, 1'b0, 1);

    // Abort mid-run: outputs clear at once and no done follows.
    @(negedge clk);
    bus.A     = 4'd10;
    bus.B     = 4'd3;
    bus.Bin   = 1'b0;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("busy_before_rst", {31'b0, bus.busy}, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'b0, bus.busy}, 0);
    chk("abort_done", {31'b0, bus.done}, 0);
    chk("abort_D", 32'(bus.D), 0);
    chk("abort_flags", {29'b0, bus.borrow_out, bus.overflow, bus.zero}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("idle_after_rst", {30'b0, bus.busy, bus.done}, 0);
    run_op(4'd6, 4'd6, 1'b0, 0);

    for (int i = 0; i < 8; i++) begin
      run_op(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 0);
    end

    repeat (3) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
